mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_load_formatter.sv | 28 ++
 rtl/mem_access_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the data-memory access unit.
// Holds the FSM state, MemSize codes, byte-enable patterns and default timeout.
package mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_load_formatter.sv
// mem_load_formatter: picks the addressed lane out of a bus word and extends it.
// Ports: rdata_i bus word, lane_i byte lane, size_i MemSize code,
//        unsigned_i zero-extend select, result_o formatted load value.
module mem_load_formatter
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] result_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted  = rdata_i >> {lane_i, 3'b000};
        result_o = shifted;
        case (size_i)
            SZ_BYTE: result_o = {{24{~unsigned_i & shifted[7]}},
                                 shifted[7:0]};
            SZ_HALF: result_o = {{16{~unsigned_i & shifted[15]}},
                                 shifted[15:0]};
            default: result_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine driving a req/ack data bus
// with a bus timeout. Ports: pipeline side MemReadIn, MemWriteIn,
// EXE_MEM_Result (address), EXE_MEM_WriteData, MemSize/MemUnsigned;
// bus side dmem_*; status MEM_Result, MEM_Stall, MEM_AddrErr, MEM_BusErr.
// Build option: define MEM_SUBWORD_EN for byte/half accesses.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemReadIn,
    input  logic        MemWriteIn,
    input  logic [31:0] EXE_MEM_Result,
    input  logic [31:0] EXE_MEM_WriteData,
`ifdef MEM_SUBWORD_EN
    input  logic [1:0]  MemSize,
    input  logic        MemUnsigned,
`endif
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] MEM_Result,
    output logic        MEM_Stall,
    output logic        MEM_AddrErr,
    output logic        MEM_BusErr
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] result_q, result_d;

    logic        access;
    logic        misaligned;
    logic        timeout;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [31:0] ld_data;

    assign access  = MemReadIn | MemWriteIn;
    // Counter holds the number of ack-less BUSY cycles already spent.
    assign timeout = (cnt_q == TO_LAST);

`ifdef MEM_SUBWORD_EN
    logic [1:0] lane;
    logic [1:0] size_q, size_d;
    logic [1:0] lane_q, lane_d;
    logic       uns_q, uns_d;

    assign lane = EXE_MEM_Result[1:0];

    always_comb begin
        misaligned = 1'b0;
        st_wdata   = EXE_MEM_WriteData;
        st_be      = BE_WORD;
        case (MemSize)
            SZ_BYTE: begin
                st_wdata = {4{EXE_MEM_WriteData[7:0]}};
                st_be    = BE_BYTE << lane;
            end
            SZ_HALF: begin
                misaligned = lane[0];
                st_wdata   = {2{EXE_MEM_WriteData[15:0]}};
                st_be      = BE_HALF << lane;
            end
            SZ_WORD: misaligned = |lane;
            // Reserved code behaves as a word access.
            default: misaligned = |lane;
        endcase
    end

    mem_load_formatter u_fmt (
        .rdata_i    (dmem_rdata),
        .lane_i     (lane_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .result_o   (ld_data)
    );
`else
    assign misaligned = |EXE_MEM_Result[1:0];
    assign st_wdata   = EXE_MEM_WriteData;
    assign st_be      = BE_WORD;
    assign ld_data    = dmem_rdata;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        result_d    = result_q;
`ifdef MEM_SUBWORD_EN
        size_d      = size_q;
        lane_d      = lane_q;
        uns_d       = uns_q;
`endif
        MEM_Result  = result_q;
        MEM_Stall   = 1'b0;
        MEM_AddrErr = 1'b0;
        MEM_BusErr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        MEM_AddrErr = 1'b1;
                        MEM_Result  = '0;
                    end else begin
                        MEM_Stall = 1'b1;
                        // Read+write together is taken as a store.
                        we_d      = MemWriteIn;
                        addr_d    = {EXE_MEM_Result[31:2], 2'b00};
                        wdata_d   = st_wdata;
                        be_d      = st_be;
                        cnt_d     = '0;
                        state_d   = BUSY;
`ifdef MEM_SUBWORD_EN
                        size_d    = MemSize;
                        lane_d    = lane;
                        uns_d     = MemUnsigned;
`endif
                    end
                end
            end
            BUSY: begin
                // Ack beats a simultaneous timeout.
                if (dmem_ack) begin
                    state_d = IDLE;
                    if (!we_q) begin
                        MEM_Result = ld_data;
                        result_d   = ld_data;
                    end
                end else if (timeout) begin
                    MEM_BusErr = 1'b1;
                    MEM_Result = '0;
                    cnt_d      = '0;
                    state_d    = IDLE;
                end else begin
                    MEM_Stall = 1'b1;
                    cnt_d     = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            result_q <= '0;
`ifdef MEM_SUBWORD_EN
            size_q   <= SZ_WORD;
            lane_q   <= '0;
            uns_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            result_q <= result_d;
`ifdef MEM_SUBWORD_EN
            size_q   <= size_d;
            lane_q   <= lane_d;
            uns_q    <= uns_d;
`endif
        end
    end

    assign dmem_req   = (state_q == BUSY);
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;

endmodule
